// File: rtl/ram_arbiter_pkg.sv
// Shared RAM command encodings and arbiter FSM states.
// Latency/backpressure: n/a (definitions only).
package ram_arbiter_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  function automatic logic [1:0] cmd_of(input logic we);
    return we ? CMD_WR : CMD_RD;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker; combinational, zero latency.
// Backpressure: none, the caller decides when a pick is consumed.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic any_vld,
  output logic pick
);

  assign any_vld = req0 | req1;
  // On a tie the port that did not win last time goes first.
  assign pick    = (req0 & req1) ? ~last_gnt : req1;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter onto a single-port RAM, one transaction in flight.
// Latency: gnt at T, command T+1, rvalid T+3; requesters wait (hold req) until gnt.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DIW = 16,
  parameter int ADW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic           req1,
  input  logic           we0,
  input  logic           we1,
  input  logic [ADW-1:0] addr0,
  input  logic [ADW-1:0] addr1,
  input  logic [DIW-1:0] wdata0,
  input  logic [DIW-1:0] wdata1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           rvalid0,
  output logic           rvalid1,
  output logic [DIW-1:0] rdata0,
  output logic [DIW-1:0] rdata1,
  output logic [1:0]     ram_wr_rd,
  output logic [ADW-1:0] ram_addr,
  output logic [DIW-1:0] ram_din,
  input  logic [DIW-1:0] ram_dout,
  output logic           busy
);

  state_t         state;
  logic           last_gnt;
  logic           lat_we;
  logic           lat_port;
  logic           pick_vld;
  logic           pick;
  logic           grant;
  logic           sel_we;
  logic [ADW-1:0] sel_addr;
  logic [DIW-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .any_vld  (pick_vld),
    .pick     (pick)
  );

  // Grant is a same-cycle response to req in IDLE; held off while in reset.
  assign grant = rst_n && (state == ST_IDLE) && pick_vld;
  assign gnt0  = grant & ~pick;
  assign gnt1  = grant & pick;
  assign busy  = (state != ST_IDLE);

  always_comb begin
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_gnt  <= 1'b1;
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      ram_wr_rd <= CMD_NOP;
      ram_addr  <= '0;
      ram_din   <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            last_gnt  <= pick;
            lat_we    <= sel_we;
            lat_port  <= pick;
            ram_wr_rd <= cmd_of(sel_we);
            ram_addr  <= sel_addr;
            ram_din   <= sel_wdata;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ram_wr_rd <= CMD_NOP;
          state     <= lat_we ? ST_IDLE : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // RAM returns data one cycle after the read command.
          if (lat_port) begin
            rdata1  <= ram_dout;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= ram_dout;
            rvalid0 <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: begin
          ram_wr_rd <= CMD_NOP;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural single-port RAM.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [1:0]  ram_wr_rd;
  logic [3:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        busy;

  ram_arbiter #(.DIW(16), .ADW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .ram_wr_rd (ram_wr_rd),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .busy      (busy)
  );

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } req_t;

  typedef struct {
    int          cyc;
    logic [1:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] din;
    logic        we;
  } cmd_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [15:0] data;
  } rv_t;

  req_t gnt_q[$];
  cmd_t cmd_q[$];
  rv_t  rv_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_until = -1;
  logic [15:0] mem [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_wr_rd == 2'b10) mem[ram_addr] <= ram_din;
    if (ram_wr_rd == 2'b01) ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=event required=none (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents gnt, a RAM command or rvalid.
  always @(negedge clk) begin
    if (!rst_n) begin
      gnt_q.delete();
      cmd_q.delete();
      rv_q.delete();
      busy_until = -1;
    end else begin
      chk("busy", 32'(busy), 32'(cyc <= busy_until));
      if (gnt0 | gnt1) begin
        chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        if (gnt_q.size() == 0) fail_now("gnt_unexpected");
        else begin
          req_t e;
          e = gnt_q.pop_front();
          chk("gnt_port", 32'(gnt1), 32'(e.port));
          busy_until = cyc + (e.we ? 1 : 2);
          cmd_q.push_back('{cyc + 1, e.we ? 2'b10 : 2'b01, e.addr, e.wdata, e.we});
          if (!e.we) rv_q.push_back('{cyc + 3, e.port, e.rdata});
        end
      end
      if (ram_wr_rd != 2'b00) begin
        if (cmd_q.size() == 0) fail_now("cmd_unexpected");
        else begin
          cmd_t c;
          c = cmd_q.pop_front();
          chk("cmd_cycle", 32'(cyc), 32'(c.cyc));
          chk("cmd_code", 32'(ram_wr_rd), 32'(c.cmd));
          chk("cmd_addr", 32'(ram_addr), 32'(c.addr));
          if (c.we) chk("cmd_din", 32'(ram_din), 32'(c.din));
        end
      end
      if (rvalid0 | rvalid1) begin
        if (rv_q.size() == 0) fail_now("rvalid_unexpected");
        else begin
          rv_t r;
          r = rv_q.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
          chk("rvalid_port", 32'({rvalid1, rvalid0}), (r.port == 1) ? 32'd2 : 32'd1);
          chk("rdata", 32'(r.port == 1 ? rdata1 : rdata0), 32'(r.data));
        end
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic we, input logic [3:0] a,
                       input logic [15:0] d);
    if (p == 0) begin
      req0 = r; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic access(input int p, input logic we, input logic [3:0] a,
                        input logic [15:0] d, input logic [15:0] exp_r);
    bit got;
    got = 0;
    gnt_q.push_back('{p, we, a, d, exp_r});
    drive(p, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) got = 1;
    end
    if (!got) fail_now("gnt_timeout");
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (gnt_q.size() == 0 && cmd_q.size() == 0 && rv_q.size() == 0) done = 1;
    end
    if (!done) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic hold_tie(input int n_gnt);
    int n;
    n = 0;
    for (int i = 0; i < 40 && n < n_gnt; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) n++;
    end
    if (n < n_gnt) fail_now("tie_timeout");
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'({gnt0, gnt1}), 32'd0);
    chk({tag, "_rvalid"}, 32'({rvalid0, rvalid1}), 32'd0);
    chk({tag, "_rdata"}, {rdata1, rdata0}, 32'd0);
    chk({tag, "_ram"}, 32'({ram_wr_rd, ram_addr, ram_din}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'd0;
    ram_dout = 16'd0;
    rst_n = 1'b0;
    // Tie held from reset: both ports write, grants must alternate 0,1,0,1.
    drive(0, 1'b1, 1'b1, 4'd5, 16'h0055);
    drive(1, 1'b1, 1'b1, 4'd6, 16'h0066);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    for (int k = 0; k < 2; k++) begin
      gnt_q.push_back('{0, 1'b1, 4'd5, 16'h0055, 16'd0});
      gnt_q.push_back('{1, 1'b1, 4'd6, 16'h0066, 16'd0});
    end
    rst_n = 1'b1;
    hold_tie(4);
    drain();

    // Single write, then read-back from the other port.
    access(0, 1'b1, 4'd2, 16'd10, 16'd0);
    drain();
    access(1, 1'b0, 4'd2, 16'd0, 16'd10);
    drain();
    chk("rdata0_untouched", 32'(rdata0), 32'd0);

    // Back-to-back write then read on port 0.
    access(0, 1'b1, 4'd3, 16'd20, 16'd0);
    access(0, 1'b0, 4'd3, 16'd0, 16'd20);
    drain();
    chk("rdata1_held", 32'(rdata1), 32'd10);

    // Read the tie writes; second grant lands on the first read's rvalid cycle.
    access(0, 1'b0, 4'd5, 16'd0, 16'h0055);
    access(1, 1'b0, 4'd6, 16'd0, 16'h0066);
    drain();

    // Reset while a port 1 read sits in CAPTURE.
    access(1, 1'b0, 4'd2, 16'd0, 16'd10);
    @(posedge clk); #1;
    chk("capture_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 4'd5, 16'd0);
    drive(1, 1'b1, 1'b0, 4'd6, 16'd0);
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    gnt_q.push_back('{0, 1'b0, 4'd5, 16'd0, 16'h0055});
    gnt_q.push_back('{1, 1'b0, 4'd6, 16'd0, 16'h0066});
    rst_n = 1'b1;
    hold_tie(2);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty", 32'(gnt_q.size() + cmd_q.size() + rv_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
